// File: rtl/if_prefetch_queue_pkg.sv
// if_prefetch_queue_pkg: shared constants, state encoding and queue entry layout for the fetch front end
package if_prefetch_queue_pkg;

    localparam logic [31:0] IF_NOP           = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          ENTRY_W          = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_prefetch_queue_fetch_fifo.sv
// if_prefetch_queue_fetch_fifo: DEPTH-entry circular buffer of {instr, pc_add4} with clear-over-push/pop priority
module if_prefetch_queue_fetch_fifo
    import if_prefetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = ENTRY_W
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [W-1:0]  mem [DEPTH];
    logic          do_pop;

    assign do_pop = pop && count != '0;
    assign rdata  = mem[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
            count  <= count + CW'(push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: entries are only visible once count covers them
    always_ff @(posedge clk_i) begin
        if (push && !clear)
            mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: sequential instruction prefetcher with one outstanding imem request,
// a DEPTH-word buffer feeding IF/ID, and branch redirect/flush handling.
module if_prefetch_queue
    import if_prefetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        deq_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_add4_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t       state, state_d;
    logic [31:0]        fetch_pc, fetch_pc_d, addr_d, next_addr, target;
    logic               req_d, push, pop;
    logic [CW-1:0]      count, count_d;
    logic [ENTRY_W-1:0] head;

    assign next_addr = imem_addr_o + 32'd4;
    assign target    = redirect_pc_i & ~32'h3;
    assign valid_o   = count != '0;
    assign pop       = deq_i && valid_o;
    assign push      = state == WAIT && imem_ack_i && !redirect_i;
    assign count_d   = count + CW'(push) - CW'(pop);
    assign {instr_o, pc_add4_o} = valid_o ? head : {IF_NOP, 32'h0};

    if_prefetch_queue_fetch_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clear (redirect_i),
        .push  (push),
        .pop   (pop),
        .wdata ({imem_rdata_i, next_addr}),
        .rdata (head),
        .count (count)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            imem_req_o  <= 1'b0;
            imem_addr_o <= RESET_PC;
        end else begin
            state       <= state_d;
            fetch_pc    <= fetch_pc_d;
            imem_req_o  <= req_d;
            imem_addr_o <= addr_d;
        end
    end

    // A request may only be abandoned through DROP, which still waits for its ack
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = (!redirect_i && count < CW'(DEPTH)) ? WAIT : IDLE;
            WAIT:    state_d = redirect_i ? (imem_ack_i ? IDLE : DROP)
                             : !imem_ack_i ? WAIT
                             : (count_d < CW'(DEPTH)) ? WAIT : IDLE;
            DROP:    state_d = imem_ack_i ? IDLE : DROP;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_d      = state_d != IDLE;
        addr_d     = (state == IDLE && state_d == WAIT) ? fetch_pc
                   : (push && state_d == WAIT) ? next_addr : imem_addr_o;
        fetch_pc_d = redirect_i ? target : push ? next_addr : fetch_pc;
    end

    ack_never_full: assert property (@(posedge clk_i) disable iff (!rst_i)
        imem_ack_i && imem_req_o |-> count != CW'(DEPTH));

endmodule

// File: tb/tb_if_prefetch_queue.sv
// tb_if_prefetch_queue: directed vector table plus hand-written redirect/wrap/reset sequences
module tb_if_prefetch_queue;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        deq_i = 1'b0;
    logic        valid_o;
    logic [31:0] instr_o, pc_add4_o;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;

    int n_cmp = 0;
    int n_bad = 0;
    int mem_lat = 1;
    bit mem_en = 1'b1;
    bit stale_ack = 1'b0;
    bit seen_valid = 1'b0;

    typedef struct {
        bit          rst;
        bit          deq;
        bit          v;
        logic [31:0] instr;
        logic [31:0] pc4;
        bit          req;
        logic [31:0] addr;
    } vec_t;

    vec_t vt [14];

    if_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .deq_i         (deq_i),
        .valid_o       (valid_o),
        .instr_o       (instr_o),
        .pc_add4_o     (pc_add4_o),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_rdata_i  (imem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Memory: acks after mem_lat cycles of a held request, data = addr ^ A5A5_0000
    initial begin
        int wcnt = 0;
        forever begin
            @(posedge clk_i); #1;
            if (!mem_en) begin
                imem_ack_i = stale_ack;
                imem_rdata_i = 32'hDEAD_BEEF;
                wcnt = 0;
            end else if (imem_req_o && wcnt + 1 >= mem_lat) begin
                imem_ack_i = 1'b1;
                imem_rdata_i = imem_addr_o ^ 32'hA5A5_0000;
                wcnt = 0;
            end else begin
                imem_ack_i = 1'b0;
                wcnt = imem_req_o ? wcnt + 1 : 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        redirect_i = 1'b0;
        deq_i = 1'b0;
        #1;
        chk("rst.req", 32'(imem_req_o), 32'd0);
        chk("rst.addr", imem_addr_o, 32'h0);
        chk("rst.valid", 32'(valid_o), 32'd0);
        chk("rst.instr", instr_o, 32'h0);
        chk("rst.pc4", pc_add4_o, 32'h0);
        cyc();
        #2 rst_i = 1'b1;
    endtask

    task automatic wait_req(input logic [31:0] a, input string nm);
        int n = 0;
        while (!(imem_req_o && imem_addr_o == a) && n < 30) begin
            cyc();
            seen_valid |= valid_o;
            n++;
        end
        chk({nm, ".req"}, 32'(imem_req_o), 32'd1);
        chk({nm, ".addr"}, imem_addr_o, a);
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        while (!valid_o && n < 30) begin
            cyc();
            n++;
        end
        chk({nm, ".valid"}, 32'(valid_o), 32'd1);
    endtask

    initial begin
        vt[0]  = '{1, 1, 0, 32'h0,         32'h0,  1, 32'h0};
        vt[1]  = '{0, 1, 1, 32'hA5A5_0000, 32'h4,  1, 32'h4};
        vt[2]  = '{0, 1, 1, 32'hA5A5_0004, 32'h8,  1, 32'h8};
        vt[3]  = '{0, 1, 1, 32'hA5A5_0008, 32'hC,  1, 32'hC};
        vt[4]  = '{0, 1, 1, 32'hA5A5_000C, 32'h10, 1, 32'h10};
        vt[5]  = '{1, 0, 0, 32'h0,         32'h0,  1, 32'h0};
        vt[6]  = '{0, 0, 1, 32'hA5A5_0000, 32'h4,  1, 32'h4};
        vt[7]  = '{0, 0, 1, 32'hA5A5_0000, 32'h4,  1, 32'h8};
        vt[8]  = '{0, 0, 1, 32'hA5A5_0000, 32'h4,  1, 32'hC};
        vt[9]  = '{0, 0, 1, 32'hA5A5_0000, 32'h4,  0, 32'hC};
        vt[10] = '{0, 0, 1, 32'hA5A5_0000, 32'h4,  0, 32'hC};
        vt[11] = '{0, 1, 1, 32'hA5A5_0004, 32'h8,  0, 32'hC};
        vt[12] = '{0, 0, 1, 32'hA5A5_0004, 32'h8,  1, 32'h10};
        vt[13] = '{0, 0, 1, 32'hA5A5_0004, 32'h8,  0, 32'h10};

        #1;
        mem_lat = 1;
        for (int i = 0; i < 14; i++) begin
            if (vt[i].rst) do_reset();
            deq_i = vt[i].deq;
            cyc();
            chk($sformatf("v%0d.valid", i), 32'(valid_o), 32'(vt[i].v));
            chk($sformatf("v%0d.instr", i), instr_o, vt[i].instr);
            chk($sformatf("v%0d.pc4", i), pc_add4_o, vt[i].pc4);
            chk($sformatf("v%0d.req", i), 32'(imem_req_o), 32'(vt[i].req));
            chk($sformatf("v%0d.addr", i), imem_addr_o, vt[i].addr);
        end

        // Redirect while waiting on a 3-cycle ack for 0x8
        mem_lat = 3;
        do_reset();
        deq_i = 1'b1;
        wait_req(32'h8, "drop.req8");
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0000_0103;
        cyc();
        redirect_i = 1'b0;
        chk("drop.valid", 32'(valid_o), 32'd0);
        chk("drop.req_held", 32'(imem_req_o), 32'd1);
        chk("drop.addr_held", imem_addr_o, 32'h8);
        seen_valid = 1'b0;
        wait_req(32'h100, "drop.req100");
        chk("drop.no_stale_valid", 32'(seen_valid), 32'd0);
        wait_valid("drop.head");
        chk("drop.pc4", pc_add4_o, 32'h104);
        chk("drop.instr", instr_o, 32'hA5A5_0100);

        // Redirect coinciding with an ack and a pop, then a wrap-around target
        mem_lat = 1;
        do_reset();
        deq_i = 1'b1;
        cyc();
        cyc();
        chk("rap.pre_valid", 32'(valid_o), 32'd1);
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0000_0200;
        cyc();
        redirect_i = 1'b0;
        chk("rap.valid", 32'(valid_o), 32'd0);
        chk("rap.req", 32'(imem_req_o), 32'd0);
        cyc();
        chk("rap.req2", 32'(imem_req_o), 32'd1);
        chk("rap.addr2", imem_addr_o, 32'h200);
        chk("rap.valid2", 32'(valid_o), 32'd0);
        cyc();
        chk("rap.valid3", 32'(valid_o), 32'd1);
        chk("rap.pc4", pc_add4_o, 32'h204);
        chk("rap.instr", instr_o, 32'hA5A5_0200);
        redirect_i = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        cyc();
        redirect_i = 1'b0;
        chk("wrap.valid0", 32'(valid_o), 32'd0);
        chk("wrap.req0", 32'(imem_req_o), 32'd0);
        cyc();
        chk("wrap.req", 32'(imem_req_o), 32'd1);
        chk("wrap.addr", imem_addr_o, 32'hFFFF_FFFC);
        cyc();
        chk("wrap.valid", 32'(valid_o), 32'd1);
        chk("wrap.pc4", pc_add4_o, 32'h0);
        chk("wrap.instr", instr_o, 32'h5A5A_FFFC);
        chk("wrap.next_addr", imem_addr_o, 32'h0);

        // Asynchronous reset in the middle of a 3-cycle wait, with a stale ack afterwards
        mem_lat = 3;
        do_reset();
        deq_i = 1'b0;
        cyc();
        chk("arst.pre_req", 32'(imem_req_o), 32'd1);
        cyc();
        #2;
        rst_i = 1'b0;
        mem_en = 1'b0;
        stale_ack = 1'b1;
        #1;
        chk("arst.req", 32'(imem_req_o), 32'd0);
        chk("arst.valid", 32'(valid_o), 32'd0);
        chk("arst.addr", imem_addr_o, 32'h0);
        cyc();
        #2 rst_i = 1'b1;
        @(posedge clk_i);
        stale_ack = 1'b0;
        mem_en = 1'b1;
        mem_lat = 1;
        @(negedge clk_i);
        chk("arst.stale_valid", 32'(valid_o), 32'd0);
        chk("arst.restart_req", 32'(imem_req_o), 32'd1);
        chk("arst.restart_addr", imem_addr_o, 32'h0);
        cyc();
        chk("arst.head_valid", 32'(valid_o), 32'd1);
        chk("arst.head_instr", instr_o, 32'hA5A5_0000);
        chk("arst.head_pc4", pc_add4_o, 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/if_prefetch_queue.md
Name: if_prefetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register.
- Fetches sequential words from an instruction memory with variable latency over a req/ack handshake. Buffers up to DEPTH fetched words.
- Presents the head word plus its pc+4 to IF/ID.
- The pipe's write-enable pops the head. A taken branch from the MEM stage redirects fetch and flushes the buffer.

Parameters:
- DEPTH, 4, number of queue entries (power of two, ≥2).
- RESET_PC, 32'h0000_0000, fetch address after reset.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- redirect_i  in  1  taken branch (MEM_PCSrc); flushes the queue and restarts fetch.
- redirect_pc_i  in  32  branch target; bits [1:0] are ignored and forced to 0.
- deq_i  in  1  IF/ID write enable; pops the head when valid_o=1.
- valid_o  out  1  head entry valid.
- instr_o  out  32  head instruction; 32'h0 (NOP) when valid_o=0.
- pc_add4_o  out  32  head address + 4; 32'h0 when valid_o=0.
- imem_req_o  out  1  memory request, registered.
- imem_addr_o  out  32  request address, registered; stable while imem_req_o=1.
- imem_ack_i  in  1  one-cycle response strobe; only legal while imem_req_o=1.
- imem_rdata_i  in  32  instruction word; valid with imem_ack_i.

Behaviour:
- Reset (async, rst_i=0):
  - fetch_pc=RESET_PC, count=0, rd_ptr=wr_ptr=0, state=IDLE.
  - imem_req_o=0, imem_addr_o=RESET_PC, valid_o=0, instr_o=0, pc_add4_o=0.
- Only one outstanding request. Once raised, a request cannot be withdrawn before its ack.
- States:
  - IDLE: if count<DEPTH and !redirect_i → WAIT, with imem_req_o=1 and imem_addr_o=fetch_pc from the next cycle.
  - WAIT, on imem_ack_i with no redirect:
    - Enqueue {imem_rdata_i, imem_addr_o+4} and set fetch_pc=imem_addr_o+4.
    - count_next=count+1-pop. If count_next<DEPTH, stay in WAIT with imem_addr_o=imem_addr_o+4 (back-to-back fetch, one word per ack). Otherwise go to IDLE with imem_req_o=0.
  - WAIT, no ack: hold imem_req_o and imem_addr_o.
  - DROP: hold imem_req_o and the old address until imem_ack_i, then discard the data and go to IDLE with imem_req_o=0.
- Room is always reserved before a request issues, so an ack never arrives to a full queue. An ack while full is a protocol error (assertion).
- Pop: when deq_i & valid_o, rd_ptr++ and count--. deq_i while empty is ignored.
- Simultaneous pop and enqueue: count is unchanged and both pointers advance.
- Head outputs are combinational from storage[rd_ptr], gated to 0 when empty. Latency from ack to valid_o is 1 cycle.
- Redirect has priority over pop, enqueue and issue:
  - Queue cleared: count=0 and pointers reset. fetch_pc={redirect_pc_i[31:2],2'b00}.
  - From IDLE: stay in IDLE; the request to the new pc issues the next cycle.
  - From WAIT without ack that cycle: go to DROP.
  - From WAIT with ack that cycle: discard the data and go to IDLE.
  - In DROP: update fetch_pc only; stay in DROP.
  - valid_o=0 in the cycle after redirect.
- Arithmetic: 32-bit, wraps modulo 2^32 (0xFFFF_FFFC+4 → 0x0000_0000).
- Reset mid-request: state and outputs return to reset values immediately. A late ack after reset is ignored because imem_req_o=0.

Decomposition:
- Shared package holds:
  - IF_NOP = 32'h0.
  - Default RESET_PC.
  - State encoding: IDLE=2'd0, WAIT=2'd1, DROP=2'd2.
  - Queue entry width constant 64 ({instr, pc_add4}).
- One natural sub-module, fetch_fifo: DEPTH×64 storage, pointers, count, with push, pop and clear inputs. Clear has priority. Push and pop in the same cycle are allowed.
- The FSM, fetch_pc and memory interface live in the top of the block.

Test Plan:
- Reset, then 1-cycle-latency memory returning word = addr ^ 32'hA5A5_0000, deq_i=1 always:
  - Requests go to 0, 4, 8, … back-to-back.
  - The first valid_o occurs 2 cycles after reset release, with instr_o=32'hA5A5_0000 and pc_add4_o=4.
- Fill and stall: deq_i=0:
  - Exactly DEPTH=4 words are enqueued (addresses 0–C), then imem_req_o drops to 0.
  - Raise deq_i for 1 cycle: one request, to address 0x10, issues.
- Redirect during WAIT with a 3-cycle ack latency: redirect_i with redirect_pc_i=32'h0000_0103 one cycle after the request to 0x8:
  - Queue empties and the state becomes DROP.
  - The ack for 0x8 is discarded and the next request goes to 0x100.
  - The first valid head has pc_add4_o=0x104.
- Redirect in the same cycle as an ack and a pop: the acked data is not enqueued, count=0 the next cycle, and the next request goes to the redirect target.
- Wrap: redirect to 0xFFFF_FFFC → request 0xFFFF_FFFC, head pc_add4_o=0, next request 0x0.
- Async reset asserted mid-WAIT (asynchronously, between clock edges): imem_req_o=0 and valid_o=0 at once. After release, fetch restarts at RESET_PC and a stale ack is ignored.
